// File: rtl/debug_trace_reader_pkg.sv
// Shared types and constants for the pipeline handshake trace reader.
package debug_trace_reader_pkg;

  localparam int unsigned NUM_EVT = 8;
  localparam int unsigned TS_W    = 24;
  localparam int unsigned TRACE_W = NUM_EVT + TS_W;

  // Bit positions of the stage handshake flags within evt
  localparam int unsigned EVT_AGGR_RDY = 0;
  localparam int unsigned EVT_AGGR_VLD = 1;
  localparam int unsigned EVT_SM_RDY   = 2;
  localparam int unsigned EVT_SM_VLD   = 3;
  localparam int unsigned EVT_DMVM_RDY = 4;
  localparam int unsigned EVT_DMVM_VLD = 5;
  localparam int unsigned EVT_SPMM_RDY = 6;
  localparam int unsigned EVT_SPMM_VLD = 7;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StRun    = 2'b01,
    StFrozen = 2'b10
  } trace_state_e;

  typedef struct packed {
    logic [NUM_EVT-1:0] mask;
    logic [TS_W-1:0]    ts;
  } trace_entry_t;

  // Saturating increment: the run clock sticks at its maximum instead of wrapping
  function automatic logic [TS_W-1:0] ts_sat_inc(input logic [TS_W-1:0] ts);
    return (&ts) ? ts : ts + TS_W'(1);
  endfunction

endpackage

// File: rtl/debug_trace_reader_if.sv
// Host-facing bundle of the trace reader: event flags, control, and the read port.
interface debug_trace_reader_if
  import debug_trace_reader_pkg::*;
#(
  parameter int unsigned DEPTH = 64
) ();

  localparam int unsigned CNT_W = $clog2(DEPTH + 2);

  logic [NUM_EVT-1:0] evt;
  logic               arm;
  logic               stop;
  logic               clr;
  logic               rd_rdy;
  logic               rd_vld;
  logic [TRACE_W-1:0] rd_data;
  logic [CNT_W-1:0]   count;
  logic               overflow;
  logic [1:0]         state;

  modport master (
    output evt, arm, stop, clr, rd_rdy,
    input  rd_vld, rd_data, count, overflow, state
  );

  modport slave (
    input  evt, arm, stop, clr, rd_rdy,
    output rd_vld, rd_data, count, overflow, state
  );

endinterface

// File: rtl/debug_trace_reader_fifo.sv
// Synchronous FIFO with a registered output stage and synchronous flush.
module debug_trace_reader_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  output logic                         drop,
  input  logic                         pop,
  output logic                         vld,
  output logic [WIDTH-1:0]             data,
  output logic [$clog2(DEPTH+2)-1:0]   count
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned MW    = $clog2(DEPTH + 1);
  localparam int unsigned CNT_W = $clog2(DEPTH + 2);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [MW-1:0]    mem_cnt_q;
  logic             out_vld_q;
  logic [WIDTH-1:0] out_data_q;

  logic mem_full, mem_empty, pop_ok, mem_rd, mem_wr;

  assign mem_full  = (mem_cnt_q == MW'(DEPTH));
  assign mem_empty = (mem_cnt_q == '0);
  assign pop_ok    = pop & out_vld_q;
  // Output stage refills whenever it is empty or being drained this cycle
  assign mem_rd    = ~mem_empty & (~out_vld_q | pop_ok);
  // A full memory still accepts a write when the same edge frees a slot
  assign mem_wr    = push & (~mem_full | mem_rd);
  assign drop      = push & ~mem_wr;

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      mem_cnt_q <= '0;
    end else if (flush) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      mem_cnt_q <= '0;
    end else begin
      if (mem_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (mem_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({mem_wr, mem_rd})
        2'b10:   mem_cnt_q <= mem_cnt_q + MW'(1);
        2'b01:   mem_cnt_q <= mem_cnt_q - MW'(1);
        default: mem_cnt_q <= mem_cnt_q;
      endcase
    end
  end

  // Storage array, no reset needed since pointers gate visibility
  always_ff @(posedge clk) begin
    if (mem_wr) mem[wr_ptr_q] <= push_data;
  end

  // Registered output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
    end else if (flush) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
    end else if (mem_rd) begin
      out_vld_q  <= 1'b1;
      out_data_q <= mem[rd_ptr_q];
    end else if (pop_ok) begin
      out_vld_q  <= 1'b0;
    end
  end

  assign vld   = out_vld_q;
  assign data  = out_data_q;
  assign count = CNT_W'(mem_cnt_q) + CNT_W'(out_vld_q);

endmodule

// File: rtl/debug_trace_reader.sv
// Timestamped rising-edge logger for the pipeline handshake debug flags.
module debug_trace_reader
  import debug_trace_reader_pkg::*;
#(
  parameter int unsigned DEPTH = 64
) (
  input logic                 clk,
  input logic                 rst_n,
  debug_trace_reader_if.slave bus
);

  logic [NUM_EVT-1:0] evt_q, rise;
  trace_state_e       state_q, state_d;
  logic [TS_W-1:0]    ts_q, ts_d;
  logic               overflow_q;
  logic               push, drop;
  trace_entry_t       entry;

  assign rise  = bus.evt & ~evt_q;
  assign entry = '{mask: rise, ts: ts_q};

  // Previous flag values for edge detection, tracked in every state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) evt_q <= '0;
    else        evt_q <= bus.evt;
  end

  // State and timestamp registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ts_q    <= '0;
    end else begin
      state_q <= state_d;
      ts_q    <= ts_d;
    end
  end

  // Next state, timestamp and capture request; clr overrides everything
  always_comb begin
    state_d = state_q;
    ts_d    = ts_q;
    push    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.arm) begin
          state_d = StRun;
          ts_d    = '0;
        end
      end
      StRun: begin
        push = |rise;
        ts_d = ts_sat_inc(ts_q);
        if (bus.stop) state_d = StFrozen;
      end
      StFrozen: ;
      default: state_d = StIdle;
    endcase
    if (bus.clr) begin
      state_d = StIdle;
      ts_d    = '0;
      push    = 1'b0;
    end
  end

  // Sticky record that an entry was lost to a full buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        overflow_q <= 1'b0;
    else if (bus.clr)  overflow_q <= 1'b0;
    else if (drop)     overflow_q <= 1'b1;
  end

  debug_trace_reader_fifo #(
    .WIDTH (TRACE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (bus.clr),
    .push      (push),
    .push_data (entry),
    .drop      (drop),
    .pop       (bus.rd_rdy),
    .vld       (bus.rd_vld),
    .data      (bus.rd_data),
    .count     (bus.count)
  );

  assign bus.overflow = overflow_q;
  assign bus.state    = state_q;

endmodule
